// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: decodes cpu data accesses into a wait-stated synchronous
// ram region and a bank of memory-mapped I/O registers, completing each with ready/err.
module mem_bus_ctrl #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 12,
    parameter int                RAM_WAIT = 1,
    parameter int                IO_PORTS = 4,
    parameter logic [ADDR_W-1:0] IO_BASE  = 12'hF00
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic                         cpu_rd,
    input  logic                         cpu_wr,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic                         busy,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    output logic                         ram_we,
    output logic                         ram_re,
    input  logic [DATA_W-1:0]            ram_rdata,
    input  logic [IO_PORTS*DATA_W-1:0]   io_in,
    output logic [IO_PORTS*DATA_W-1:0]   io_out,
    output logic [IO_PORTS-1:0]          io_strobe
);

    localparam int CNT_W = (RAM_WAIT > 0) ? $clog2(RAM_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAM_ACC,
        S_RAM_WAIT,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          addr_q;
    logic [DATA_W-1:0]          wdata_q;
    logic                       wr_q;
    logic                       io_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [DATA_W-1:0]          rdata_q;
    logic [IO_PORTS*DATA_W-1:0] io_out_q;

    logic                       accept;
    logic [ADDR_W-1:0]          io_idx;
    logic                       io_hit;
    logic [DATA_W-1:0]          io_rd_val;
    logic [DATA_W-1:0]          done_rdata;

    assign accept = (state_q == S_IDLE) && (cpu_rd || cpu_wr);
    assign io_idx = addr_q - IO_BASE;
    assign io_hit = io_q && (io_idx < ADDR_W'(IO_PORTS));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the I/O register bank is reset along with the control state,
        // since software may observe io_out straight after reset.
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            io_q     <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            io_out_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                wr_q    <= cpu_wr;          // write wins over a simultaneous read
                io_q    <= (cpu_addr >= IO_BASE);
            end
            if (state_q == S_RAM_ACC)
                cnt_q <= CNT_W'(RAM_WAIT);
            else if (state_q == S_RAM_WAIT)
                cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == S_DONE && !wr_q)
                rdata_q <= done_rdata;
            for (int k = 0; k < IO_PORTS; k++) begin
                if (io_strobe[k])
                    io_out_q[k*DATA_W +: DATA_W] <= wdata_q;
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (accept) state_d = (cpu_addr >= IO_BASE) ? S_DONE : S_RAM_ACC;
            S_RAM_ACC:  state_d = (RAM_WAIT > 0) ? S_RAM_WAIT : S_DONE;
            S_RAM_WAIT: if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        io_rd_val = '0;
        for (int k = 0; k < IO_PORTS; k++) begin
            if (io_idx == ADDR_W'(k))
                io_rd_val = io_in[k*DATA_W +: DATA_W];
        end
        if (io_q)
            done_rdata = io_hit ? io_rd_val : '0;
        else
            done_rdata = ram_rdata;

        busy      = (state_q != S_IDLE);
        ram_we    = (state_q == S_RAM_ACC) &&  wr_q;
        ram_re    = (state_q == S_RAM_ACC) && !wr_q;
        cpu_ready = (state_q == S_DONE);
        cpu_err   = (state_q == S_DONE) && io_q && !io_hit;
        // Read data is presented live in the completion cycle, then held.
        cpu_rdata = (state_q == S_DONE && !wr_q) ? done_rdata : rdata_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        io_out    = io_out_q;
        io_strobe = '0;
        for (int k = 0; k < IO_PORTS; k++) begin
            io_strobe[k] = (state_q == S_DONE) && wr_q && io_hit && (io_idx == ADDR_W'(k));
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: main instance with RAM_WAIT=1 plus RAM_WAIT=0/3
// instances used for latency measurement.
module tb_mem_bus_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_rd, cpu_wr, lat_rd;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready, cpu_err, busy;
    logic [11:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic         ram_we, ram_re;
    logic [31:0]  ram_rdata;
    logic [127:0] io_in;
    logic [127:0] io_out;
    logic [3:0]   io_strobe;

    logic [31:0]  rdata_w0, rdata_w3, rwd_w0, rwd_w3;
    logic         rdy_w0, rdy_w3, err_w0, err_w3, busy_w0, busy_w3;
    logic [11:0]  radr_w0, radr_w3;
    logic         we_w0, we_w3, re_w0, re_w3;
    logic [127:0] ioo_w0, ioo_w3;
    logic [3:0]   stb_w0, stb_w3;

    always #5 clk = ~clk;

    mem_bus_ctrl u_dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_err(cpu_err), .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata), .io_in(io_in),
        .io_out(io_out), .io_strobe(io_strobe)
    );

    mem_bus_ctrl #(.RAM_WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(lat_rd), .cpu_wr(1'b0), .cpu_rdata(rdata_w0), .cpu_ready(rdy_w0),
        .cpu_err(err_w0), .busy(busy_w0), .ram_addr(radr_w0), .ram_wdata(rwd_w0),
        .ram_we(we_w0), .ram_re(re_w0), .ram_rdata(32'h1234_0000 | {20'h0, radr_w0}),
        .io_in(128'h0), .io_out(ioo_w0), .io_strobe(stb_w0)
    );

    mem_bus_ctrl #(.RAM_WAIT(3)) u_w3 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(lat_rd), .cpu_wr(1'b0), .cpu_rdata(rdata_w3), .cpu_ready(rdy_w3),
        .cpu_err(err_w3), .busy(busy_w3), .ram_addr(radr_w3), .ram_wdata(rwd_w3),
        .ram_we(we_w3), .ram_re(re_w3), .ram_rdata(32'h1234_0000 | {20'h0, radr_w3}),
        .io_in(128'h0), .io_out(ioo_w3), .io_strobe(stb_w3)
    );

    // Synchronous ram model: read data valid from the cycle after ram_re.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        string       tag;
        logic        is_rd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_we = 0, n_re = 0, n_ready = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [3:0]  seen_strobe;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every cpu_ready.
    always @(negedge clk) begin
        exp_t e;
        if (ram_we) n_we++;
        if (ram_re) n_re++;
        if (cpu_err && !cpu_ready) check("err_without_ready", 64'(1), 64'(0));
        if (cpu_ready) begin
            n_ready++;
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_err"}, 64'(cpu_err), 64'(e.err));
                if (e.is_rd) begin
                    check({e.tag, "_rdata"}, 64'(cpu_rdata), 64'(e.rdata));
                    last_rdata = e.rdata;
                end else begin
                    check({e.tag, "_rdata_hold"}, 64'(cpu_rdata), 64'(last_rdata));
                end
            end
        end
    end

    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   lat;
        e.tag = tag; e.is_rd = rd && !wr; e.rdata = exp_rdata; e.err = exp_err;
        sb_q.push_back(e);
        seen_strobe = 4'h0;
        lat = 0;
        @(negedge clk);
        cpu_addr = addr; cpu_wdata = wdata; cpu_rd = rd; cpu_wr = wr;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({tag, "_busy"}, 64'(busy), 64'(1));
                cpu_addr = ~addr;           // must not disturb the accepted access
                cpu_wdata = ~wdata;
            end
            if (cpu_ready) begin
                lat = c;
                seen_strobe = io_strobe;
                break;
            end
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int we0, re0, rdy0;
        int lat0, lat3, cre0, cre3;
        logic [31:0] lrd0, lrd3;

        reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; lat_rd = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; io_in = '0;

        // Reset held with random inputs: all outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_addr  = 12'($urandom);
            cpu_wdata = $urandom;
            cpu_rd    = 1'($urandom);
            cpu_wr    = 1'($urandom);
            io_in     = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("rst_ctrl", 64'({cpu_ready, cpu_err, busy, ram_we, ram_re, io_strobe}), 64'(0));
            check("rst_rdata", 64'(cpu_rdata), 64'(0));
            check("rst_ram", 64'({ram_addr, ram_wdata}), 64'(0));
            check("rst_io_out", 64'(|io_out), 64'(0));
        end
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0; io_in = '0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_busy", 64'(busy), 64'(0));
        end

        // RAM write and read-back, RAM_WAIT=1.
        we0 = n_we; re0 = n_re;
        access("ram_wr", 1'b1, 1'b0, 12'h010, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
        check("ram_wr_we_count", 64'(n_we - we0), 64'(1));
        check("ram_wr_re_count", 64'(n_re - re0), 64'(0));
        re0 = n_re;
        access("ram_rd", 1'b0, 1'b1, 12'h010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        check("ram_rd_re_count", 64'(n_re - re0), 64'(1));

        // I/O write and read.
        access("io_wr", 1'b1, 1'b0, 12'hF02, 32'h55, 1, 32'h0, 1'b0);
        check("io_wr_strobe", 64'(seen_strobe), 64'(4'b0100));
        check("io_wr_port2", 64'(io_out[64 +: 32]), 64'(32'h55));
        check("io_wr_others", 64'({io_out[96 +: 32], io_out[0 +: 64]}), 64'(0));
        io_in[32 +: 32] = 32'hA5;
        access("io_rd", 1'b0, 1'b1, 12'hF01, 32'h0, 1, 32'hA5, 1'b0);

        // Out-of-range I/O: error pulse, read returns 0, write ignored.
        access("io_rd_bad", 1'b0, 1'b1, 12'hF07, 32'h0, 1, 32'h0, 1'b1);
        access("io_wr_bad", 1'b1, 1'b0, 12'hF07, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
        check("io_wr_bad_strobe", 64'(seen_strobe), 64'(0));
        check("io_wr_bad_port2", 64'(io_out[64 +: 32]), 64'(32'h55));
        check("io_wr_bad_others", 64'({io_out[96 +: 32], io_out[0 +: 64]}), 64'(0));

        // Simultaneous rd+wr: the write wins, no ram read strobe.
        we0 = n_we; re0 = n_re;
        access("rdwr_prio", 1'b1, 1'b1, 12'h020, 32'hCAFE_F00D, 3, 32'h0, 1'b0);
        check("rdwr_we_count", 64'(n_we - we0), 64'(1));
        check("rdwr_re_count", 64'(n_re - re0), 64'(0));
        access("rdwr_readback", 1'b0, 1'b1, 12'h020, 32'h0, 3, 32'hCAFE_F00D, 1'b0);

        // Latency of the RAM_WAIT=0 and RAM_WAIT=3 builds, single-cycle request.
        lat0 = 0; lat3 = 0; cre0 = 0; cre3 = 0; lrd0 = '0; lrd3 = '0;
        @(negedge clk);
        cpu_addr = 12'h040; lat_rd = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) lat_rd = 1'b0;
            if (re_w0) cre0++;
            if (re_w3) cre3++;
            if (rdy_w0 && lat0 == 0) begin lat0 = c; lrd0 = rdata_w0; end
            if (rdy_w3 && lat3 == 0) begin lat3 = c; lrd3 = rdata_w3; end
        end
        check("w0_latency", 64'(lat0), 64'(2));
        check("w3_latency", 64'(lat3), 64'(5));
        check("w0_re_count", 64'(cre0), 64'(1));
        check("w3_re_count", 64'(cre3), 64'(1));
        check("w0_rdata", 64'(lrd0), 64'(32'h1234_0040));
        check("w3_rdata", 64'(lrd3), 64'(32'h1234_0040));

        // Reset during RAM_WAIT: access abandoned, io_out cleared.
        rdy0 = n_ready;
        @(negedge clk);
        cpu_addr = 12'h010; cpu_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; cpu_rd = 1'b0;
        #1;
        check("midrst_ram_strobes", 64'({ram_we, ram_re}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        last_rdata = 32'h0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("midrst_no_ready", 64'(n_ready - rdy0), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_io_out", 64'(|io_out), 64'(0));
        check("midrst_rdata", 64'(cpu_rdata), 64'(0));
        access("rd_after_rst", 1'b0, 1'b1, 12'h010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);

        @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
